// File: rtl/memory.sv
// memory: RV64 memory-access stage with bus handshake and load/store data formatting
module memory (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] dataEAluout,
    input  logic [63:0] dataEMemdata,
    input  logic [4:0]  dataEDst,
    input  logic [31:0] dataERawInstr,
    input  logic        dataEMemread,
    input  logic        dataEMemwrite,
    input  logic [1:0]  dataEMsize,
    input  logic        dataEMemunsigned,
    output logic        in_ready,
    output logic        dreqValid,
    output logic [63:0] dreqAddr,
    output logic [1:0]  dreqSize,
    output logic [7:0]  dreqStrobe,
    output logic [63:0] dreqData,
    input  logic        drespAddrOk,
    input  logic        drespDataOk,
    input  logic [63:0] drespData,
    output logic        out_valid,
    output logic [63:0] dataMResult,
    output logic [4:0]  dataMDst,
    output logic        dataMMemread,
    output logic        dataMMemwrite,
    output logic [1:0]  dataMMsize,
    output logic        dataMMemunsigned,
    output logic [31:0] dataMRawInstr,
    output logic        dataMMisalign
);
    typedef enum logic {IDLE, BUS} stateType;

    stateType    state, nextState;
    logic [63:0] addr, memdata, raw, loadVal;
    logic [4:0]  dst;
    logic [31:0] rawInstr;
    logic        memread, memwrite, memunsigned;
    logic [1:0]  msize;
    logic [2:0]  off;
    logic [7:0]  sizeMask;
    logic        accept, isMem, misAligned, busDone, unusedAddrOk;

    assign unusedAddrOk = drespAddrOk;
    assign accept = in_valid && in_ready;
    assign isMem = dataEMemread || dataEMemwrite;
    assign busDone = (state == BUS) && drespDataOk;
    assign off = addr[2:0];

    // alignment of the incoming access, judged before any bus request is made
    always_comb misAligned = (dataEMsize == 2'd1) ? dataEAluout[0] :
                             (dataEMsize == 2'd2) ? |dataEAluout[1:0] :
                             (dataEMsize == 2'd3) ? |dataEAluout[2:0] : 1'b0;

    // store lane shifting and byte strobes, load lane extraction and extension
    always_comb begin
        sizeMask = (msize == 2'd0) ? 8'h01 : (msize == 2'd1) ? 8'h03 : (msize == 2'd2) ? 8'h0F : 8'hFF;
        dreqStrobe = memwrite ? sizeMask << off : 8'h00;
        dreqData = memdata << {off, 3'b000};
        raw = drespData >> {off, 3'b000};
        loadVal = (msize == 2'd0) ? {{56{~memunsigned & raw[7]}}, raw[7:0]} :
                  (msize == 2'd1) ? {{48{~memunsigned & raw[15]}}, raw[15:0]} :
                  (msize == 2'd2) ? {{32{~memunsigned & raw[31]}}, raw[31:0]} : raw;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    // only aligned memory accesses enter BUS; data_ok ends the transaction
    always_comb nextState = (state == IDLE) ? ((accept && isMem && !misAligned) ? BUS : IDLE) :
                            (drespDataOk ? IDLE : BUS);

    // handshake outputs decoded from state
    always_comb begin
        in_ready = (state == IDLE);
        dreqValid = (state == BUS);
    end

    // latched instruction and writeback result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            memdata <= '0;
            dst <= '0;
            rawInstr <= '0;
            memread <= 1'b0;
            memwrite <= 1'b0;
            msize <= '0;
            memunsigned <= 1'b0;
            out_valid <= 1'b0;
            dataMResult <= '0;
            dataMMisalign <= 1'b0;
        end else begin
            if (accept) begin
                addr <= dataEAluout;
                memdata <= dataEMemdata;
                dst <= dataEDst;
                rawInstr <= dataERawInstr;
                memread <= dataEMemread;
                memwrite <= dataEMemwrite;
                msize <= dataEMsize;
                memunsigned <= dataEMemunsigned;
                dataMResult <= isMem ? 64'd0 : dataEAluout;
                dataMMisalign <= isMem && misAligned;
            end else if (busDone) begin
                dataMResult <= memread ? loadVal : 64'd0;
            end
            out_valid <= (accept && (!isMem || misAligned)) || busDone;
        end
    end

    assign dreqAddr = addr;
    assign dreqSize = msize;
    assign dataMDst = dst;
    assign dataMMemread = memread;
    assign dataMMemwrite = memwrite;
    assign dataMMsize = msize;
    assign dataMMemunsigned = memunsigned;
    assign dataMRawInstr = rawInstr;
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed checks of the memory stage against hand-computed values
module tb_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] dataEAluout = '0;
    logic [63:0] dataEMemdata = '0;
    logic [4:0]  dataEDst = '0;
    logic [31:0] dataERawInstr = '0;
    logic        dataEMemread = 1'b0;
    logic        dataEMemwrite = 1'b0;
    logic [1:0]  dataEMsize = '0;
    logic        dataEMemunsigned = 1'b0;
    logic        in_ready;
    logic        dreqValid;
    logic [63:0] dreqAddr;
    logic [1:0]  dreqSize;
    logic [7:0]  dreqStrobe;
    logic [63:0] dreqData;
    logic        drespAddrOk = 1'b0;
    logic        drespDataOk = 1'b0;
    logic [63:0] drespData = '0;
    logic        out_valid;
    logic [63:0] dataMResult;
    logic [4:0]  dataMDst;
    logic        dataMMemread;
    logic        dataMMemwrite;
    logic [1:0]  dataMMsize;
    logic        dataMMemunsigned;
    logic [31:0] dataMRawInstr;
    logic        dataMMisalign;
    int          total = 0;
    int          bad = 0;

    memory dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .dataEAluout(dataEAluout), .dataEMemdata(dataEMemdata), .dataEDst(dataEDst),
        .dataERawInstr(dataERawInstr), .dataEMemread(dataEMemread), .dataEMemwrite(dataEMemwrite),
        .dataEMsize(dataEMsize), .dataEMemunsigned(dataEMemunsigned), .in_ready(in_ready),
        .dreqValid(dreqValid), .dreqAddr(dreqAddr), .dreqSize(dreqSize), .dreqStrobe(dreqStrobe),
        .dreqData(dreqData), .drespAddrOk(drespAddrOk), .drespDataOk(drespDataOk),
        .drespData(drespData), .out_valid(out_valid), .dataMResult(dataMResult),
        .dataMDst(dataMDst), .dataMMemread(dataMMemread), .dataMMemwrite(dataMMemwrite),
        .dataMMsize(dataMMsize), .dataMMemunsigned(dataMMemunsigned),
        .dataMRawInstr(dataMRawInstr), .dataMMisalign(dataMMisalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setE(input logic [63:0] a, input logic [63:0] md, input logic [4:0] d,
                        input logic rd, input logic wr, input logic [1:0] sz, input logic un);
        dataEAluout = a;
        dataEMemdata = md;
        dataEDst = d;
        dataERawInstr = a[31:0] ^ 32'h13;
        dataEMemread = rd;
        dataEMemwrite = wr;
        dataEMsize = sz;
        dataEMemunsigned = un;
    endtask

    task automatic memOp(input string tag, input logic [63:0] a, input logic [63:0] md,
                         input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                         input logic [63:0] rdata, input int k, input logic [7:0] expStrobe,
                         input logic [63:0] expData, input logic [63:0] expRes);
        setE(a, md, 5'd7, rd, wr, sz, un);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drespData = rdata;
        for (int i = 0; i < k; i++) begin
            check({tag, ".dvalid"}, 64'(dreqValid), 64'd1);
            check({tag, ".ready"}, 64'(in_ready), 64'd0);
            check({tag, ".addr"}, dreqAddr, a);
            check({tag, ".strobe"}, 64'(dreqStrobe), 64'(expStrobe));
            check({tag, ".wdata"}, dreqData, expData);
            check({tag, ".early"}, 64'(out_valid), 64'd0);
            if (i == k - 1) drespDataOk = 1'b1;
            step();
        end
        drespDataOk = 1'b0;
        check({tag, ".ovalid"}, 64'(out_valid), 64'd1);
        check({tag, ".result"}, dataMResult, expRes);
        check({tag, ".dst"}, 64'(dataMDst), 64'd7);
        check({tag, ".idle"}, 64'(in_ready), 64'd1);
        step();
        check({tag, ".pulse"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        step();
        step();
        check("rst.ready", 64'(in_ready), 64'd1);
        check("rst.ovalid", 64'(out_valid), 64'd0);
        check("rst.dvalid", 64'(dreqValid), 64'd0);
        check("rst.addr", dreqAddr, 64'd0);
        check("rst.size", 64'(dreqSize), 64'd0);
        check("rst.strobe", 64'(dreqStrobe), 64'd0);
        check("rst.wdata", dreqData, 64'd0);
        check("rst.result", dataMResult, 64'd0);
        check("rst.dst", 64'(dataMDst), 64'd0);
        check("rst.misalign", 64'(dataMMisalign), 64'd0);
        reset = 1'b0;
        step();
        setE(64'h1234, 64'd0, 5'd5, 1'b0, 1'b0, 2'd3, 1'b0);
        in_valid = 1'b1;
        step();
        check("alu.ovalid", 64'(out_valid), 64'd1);
        check("alu.result", dataMResult, 64'h1234);
        check("alu.dst", 64'(dataMDst), 64'd5);
        check("alu.raw", 64'(dataMRawInstr), 64'h1227);
        for (int i = 0; i < 3; i++) begin
            setE(64'(i + 17), 64'd0, 5'(i + 1), 1'b0, 1'b0, 2'd0, 1'b0);
            step();
            check("b2b.ovalid", 64'(out_valid), 64'd1);
            check("b2b.result", dataMResult, 64'(i + 17));
            check("b2b.dst", 64'(dataMDst), 64'(i + 1));
        end
        in_valid = 1'b0;
        step();
        check("alu.drop", 64'(out_valid), 64'd0);
        memOp("sb", 64'h1003, 64'hAB, 1'b0, 1'b1, 2'd0, 1'b0, 64'd0, 3, 8'h08, 64'hAB00_0000, 64'd0);
        memOp("sw", 64'h1004, 64'h1122_3344, 1'b0, 1'b1, 2'd2, 1'b0, 64'd0, 2, 8'hF0,
              64'h1122_3344_0000_0000, 64'd0);
        memOp("lbs", 64'h2006, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0, 64'h0080_0000_0000_0000, 2, 8'h00, 64'd0,
              64'hFFFF_FFFF_FFFF_FF80);
        memOp("lbu", 64'h2006, 64'd0, 1'b1, 1'b0, 2'd0, 1'b1, 64'h0080_0000_0000_0000, 1, 8'h00, 64'd0,
              64'h80);
        memOp("lw", 64'h2004, 64'd0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h8765_4321_0000_0000, 2, 8'h00, 64'd0,
              64'hFFFF_FFFF_8765_4321);
        memOp("lhu", 64'h2002, 64'd0, 1'b1, 1'b0, 2'd1, 1'b1, 64'h0000_0000_BEEF_0000, 1, 8'h00, 64'd0,
              64'hBEEF);
        memOp("lhs", 64'h2002, 64'd0, 1'b1, 1'b0, 2'd1, 1'b0, 64'h0000_0000_BEEF_0000, 1, 8'h00, 64'd0,
              64'hFFFF_FFFF_FFFF_BEEF);
        memOp("ld", 64'h2008, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h8123_4567_89AB_CDEF, 1, 8'h00, 64'd0,
              64'h8123_4567_89AB_CDEF);
        setE(64'h3001, 64'd0, 5'd9, 1'b1, 1'b0, 2'd1, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("mis.ovalid", 64'(out_valid), 64'd1);
        check("mis.flag", 64'(dataMMisalign), 64'd1);
        check("mis.result", dataMResult, 64'd0);
        check("mis.dvalid", 64'(dreqValid), 64'd0);
        check("mis.ready", 64'(in_ready), 64'd1);
        step();
        check("mis.dvalid2", 64'(dreqValid), 64'd0);
        check("mis.pulse", 64'(out_valid), 64'd0);
        setE(64'h4000, 64'd0, 5'd3, 1'b1, 1'b0, 2'd3, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("rb.dvalid", 64'(dreqValid), 64'd1);
        check("rb.flagclr", 64'(dataMMisalign), 64'd0);
        #1 reset = 1'b1;
        #1;
        check("rb.dvalid0", 64'(dreqValid), 64'd0);
        check("rb.ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        step();
        drespDataOk = 1'b1;
        step();
        drespDataOk = 1'b0;
        check("rb.noout", 64'(out_valid), 64'd0);
        check("rb.idle", 64'(dreqValid), 64'd0);
        step();
        check("rb.noout2", 64'(out_valid), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory.md
# memory

Memory-access stage of the five-stage RV64 pipeline. Consumes `execute_data_t` from the execute stage, performs loads and stores on the data bus through a valid/data_ok handshake, formats load data (byte-lane extraction, sign/zero extension) and store data (lane shift, byte strobes), and presents `memory_data_t` to writeback. Holds the upstream pipeline via `in_ready` while a bus transaction is outstanding.

## Interface

Parameters:
- none; widths fixed by `common`/`pipes` (`word_t` = 64 bits, `msize_t` = 2 bits).

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  `dataE` holds a live instruction.
- `dataE`  in  `execute_data_t`  fields used:
  - `aluout`: effective address or result.
  - `memdata`: store data, 64.
  - `dst`: 5.
  - `raw_instr`: 32.
  - `ctl.memread`, `ctl.memwrite`, `ctl.msize` (0=B, 1=H, 2=W, 3=D), `ctl.memunsigned`.
- `in_ready`  out  1  stage accepts `dataE` this cycle.
- `dreq`  out  `dbus_req_t`  fields `valid`, `addr` (64), `size` (msize_t), `strobe` (8), `data` (64).
- `dresp`  in  `dbus_resp_t`  fields `addr_ok`, `data_ok`, `data` (64); `addr_ok` unused.
- `out_valid`  out  1  `dataM` valid, one-cycle pulse per instruction.
- `dataM`  out  `memory_data_t`  fields `result` (64), `dst`, `ctl`, `raw_instr`, `misalign` (1).

## Operation

FSM states: IDLE, BUS.
- `in_ready` = (state == IDLE). Accept = `in_valid && in_ready` at a rising edge; the instruction is latched into an internal register (`addr`, `memdata`, `dst`, `ctl`, `raw_instr`).
- Accepting from IDLE:
  - Non-memory instruction (`memread` = `memwrite` = 0): stays IDLE. Next cycle `out_valid` = 1 and `dataM.result` = `aluout`.
  - Memory instruction, aligned: goes to BUS.
  - Memory instruction, misaligned (`addr[size-1:0]` not 0 for H/W/D): no bus access, stays IDLE. Next cycle `out_valid` = 1, `dataM.misalign` = 1, `result` = 0.
- BUS:
  - `dreq.valid` = 1. `addr`, `size`, `strobe` and `data` come from the latched register and are stable until completion.
  - Leaves for IDLE at the edge where `dresp.data_ok` = 1, capturing the formatted result. `out_valid` = 1 the following cycle.
  - `in_valid` is ignored while in BUS.
- Store formatting:
  - `off` = `addr[2:0]`.
  - `strobe` = (`8'h01`, `8'h03`, `8'h0F`, `8'hFF` for B/H/W/D) << `off`.
  - `data` = `memdata` << (8 × `off`).
  - Store `result` = 0.
- Load formatting:
  - `strobe` = 0.
  - `raw` = `dresp.data` >> (8 × `off`); truncate to the access size.
  - Extend to 64 bits: zero-extend if `memunsigned`, else sign-extend. D is never extended.
- `dataM.dst`, `ctl` and `raw_instr` pass through from the latched register.

## Timing

- Reset values:
  - state = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `dreq.valid` = 0; `dreq.addr`, `size`, `strobe`, `data` = 0.
  - All `dataM` fields = 0, including `misalign` = 0.
- Non-memory and misaligned instructions: latency 1, throughput 1 per cycle; back-to-back accepts allowed.
- Memory instructions:
  - Accepted at edge T.
  - `dreq.valid` rises after T.
  - `data_ok` sampled high at edge T+k, k ≥ 1.
  - `out_valid` is high in cycle T+k → T+k+1.
  - `in_ready` is low from after T until after T+k, so the next accept is at the earliest at edge T+k+1.
- `data_ok` at the first BUS cycle is legal (minimum 2-cycle latency). `data_ok` seen in IDLE is ignored.
- `out_valid` is never held: writeback always consumes it.
- Reset asserted mid-BUS: FSM returns to IDLE, `dreq.valid` drops immediately, the pending instruction is discarded, and no `out_valid` is produced.

## Test plan

- Reset, then a non-mem instruction with `aluout` = 0x1234 and `dst` = 5 → one cycle later `out_valid` = 1, `result` = 0x1234, `dst` = 5. Three back-to-back ALU ops give three consecutive `out_valid` cycles.
- SB at `addr` 0x1003 with `memdata` = 0xAB, `data_ok` after 3 BUS cycles → `dreq.strobe` = 0x08, `dreq.data` = 0xAB000000, held stable for all 3 cycles; `in_ready` = 0 for those cycles; one `out_valid` follows.
- LB at 0x2006 with `dresp.data` = 0x0080_0000_0000_0000:
  - signed → `result` = 0xFFFF_FFFF_FFFF_FF80.
  - `memunsigned` → `result` = 0x80.
- LW at 0x2004 with `dresp.data` = 0x8765_4321_0000_0000, signed → `result` = 0xFFFF_FFFF_8765_4321. LD with `data_ok` in the first BUS cycle → `out_valid` 2 cycles after accept.
- LH at 0x3001 (misaligned) → `dreq.valid` never rises; next cycle `out_valid` = 1, `misalign` = 1, `result` = 0.
- Reset pulse while in BUS with `data_ok` = 0 → `dreq.valid` = 0 and `in_ready` = 1 immediately; a later `data_ok` = 1 produces no `out_valid`.
